// File: rtl/dac_spi_tx_pkg.sv
// Shared constants, FSM encoding and frame builder for the DAC SPI transmitter.
package dac_spi_tx_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 10;
  localparam int BIT_CNT_W  = 6;
  // 16 rising plus 16 falling SCK edges; ticks are numbered 0..31
  localparam int LAST_TICK  = 2 * FRAME_BITS - 1;

  // write-A, buffered, 1x gain, active
  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  // Frame layout: config nibble, sample, two don't-care LSBs sent as zero
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0]           cfg,
                                                        input logic [DATA_BITS-1:0] sample);
    return {cfg, sample, 2'b00};
  endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample/handshake side and DAC pin side of the transmitter, bundled.
interface dac_spi_tx_if;
  import dac_spi_tx_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 load;
  logic                 dac_cs;
  logic                 dac_sck;
  logic                 dac_sdi;
  logic                 dac_ld;
  logic                 busy;
  logic                 done;

  // Processor side: supplies samples, observes the DAC pins and status
  modport master (
    output data_in, load,
    input  dac_cs, dac_sck, dac_sdi, dac_ld, busy, done
  );

  // Transmitter side
  modport slave (
    input  data_in, load,
    output dac_cs, dac_sck, dac_sdi, dac_ld, busy, done
  );

endinterface

// File: rtl/dac_spi_tx_sck_tick_gen.sv
// Half-period counter: counts 0..CLK_DIV-1 and flags the wrap as a tick.
module sck_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = !clr && (cnt == LAST);

  // Count up, wrap on tick, hold at zero while cleared
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one 16-bit DAC command per load: SPI shift, then an LDAC strobe.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int         CLK_DIV = 25,
  parameter logic [3:0] DAC_CFG = DAC_CFG_DEFAULT
) (
  input  logic       sysclk,
  input  logic       reset,
  dac_spi_tx_if.slave bus
);

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic                  sck_q, sck_d;
  logic                  done_d;
  logic                  cs_q, ld_q, busy_q, done_q;
  logic                  tick;
  logic                  cnt_clr;

  // Counter sits at zero in IDLE so SHIFT always starts on a fresh half-period
  assign cnt_clr = (state_q == ST_IDLE);

  sck_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .clr    (cnt_clr),
    .tick   (tick)
  );

  // Next-state and datapath decisions
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sck_d = 1'b0;
        if (bus.load) begin
          shreg_d = build_frame(DAC_CFG, bus.data_in);
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          bit_d = bit_q + 1'b1;
          sck_d = ~sck_q;
          // SDI is the shift register MSB, so it only moves on SCK falling edges
          if (sck_q) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end
          if (bit_q == BIT_CNT_W'(LAST_TICK)) begin
            state_d = ST_LATCH;
            sck_d   = 1'b0;
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered pin outputs, decoded from the upcoming state
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      ld_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      cs_q    <= (state_d != ST_SHIFT);
      ld_q    <= (state_d != ST_LATCH);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  assign bus.dac_cs  = cs_q;
  assign bus.dac_sck = sck_q;
  assign bus.dac_sdi = shreg_q[FRAME_BITS-1];
  assign bus.dac_ld  = ld_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=25.
module tb_dac_spi_tx;

  logic sysclk = 1'b0;
  logic rst;
  always #5 sysclk = ~sysclk;

  dac_spi_tx_if ifa ();
  dac_spi_tx_if ifb ();

  dac_spi_tx #(.CLK_DIV(2), .DAC_CFG(4'b0111)) dut_a (.sysclk(sysclk), .reset(rst), .bus(ifa));
  dac_spi_tx #(.CLK_DIV(25))                   dut_b (.sysclk(sysclk), .reset(rst), .bus(ifb));

  logic       ld_in [2];
  logic [9:0] din   [2];
  logic o_cs [2], o_sck [2], o_sdi [2], o_ld [2], o_busy [2], o_done [2];

  assign ifa.load = ld_in[0];  assign ifa.data_in = din[0];
  assign ifb.load = ld_in[1];  assign ifb.data_in = din[1];
  assign o_cs[0]   = ifa.dac_cs;   assign o_cs[1]   = ifb.dac_cs;
  assign o_sck[0]  = ifa.dac_sck;  assign o_sck[1]  = ifb.dac_sck;
  assign o_sdi[0]  = ifa.dac_sdi;  assign o_sdi[1]  = ifb.dac_sdi;
  assign o_ld[0]   = ifa.dac_ld;   assign o_ld[1]   = ifb.dac_ld;
  assign o_busy[0] = ifa.busy;     assign o_busy[1] = ifb.busy;
  assign o_done[0] = ifa.done;     assign o_done[1] = ifb.done;

  function automatic int cd_of(input int i);
    return (i == 0) ? 2 : 25;
  endfunction

  // ---------------- reference model ----------------
  // m_k: cycles since the frame was accepted (-1 = idle); 33*cd is the done cycle
  int          m_k  [2] = '{-1, -1};
  logic [15:0] m_fr [2];

  always @(posedge sysclk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_k[i] <= -1;
      end else if (m_k[i] < 0 || m_k[i] == 33 * cd_of(i)) begin
        if (ld_in[i]) begin
          m_k[i]  <= 0;
          m_fr[i] <= {4'b0111, din[i], 2'b00};
        end else begin
          m_k[i] <= -1;
        end
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  // Expected {cs, sck, sdi, ld, busy, done} at timeline position k; mask drops sdi outside SHIFT
  function automatic void expect_out(input int k, input int cd, input logic [15:0] fr,
                                     output logic [5:0] e, output logic [5:0] m);
    e = 6'b100100;
    m = 6'b110111;
    if (k == 33 * cd) begin
      e = 6'b100101;
    end else if (k >= 0 && k < 32 * cd) begin
      e = {1'b0, 1'((k / cd) % 2), fr[15 - k / (2 * cd)], 1'b1, 1'b1, 1'b0};
      m = 6'b111111;
    end else if (k >= 32 * cd) begin
      e = 6'b100010;
    end
  endfunction

  // ---------------- observation ----------------
  int          cs_low [2], ld_low [2], busy_hi [2], done_n [2];
  logic [15:0] fr_obs [2];
  longint      rise_prev [2], rise_last [2];

  always @(negedge sysclk) begin
    for (int i = 0; i < 2; i++) begin
      if (o_cs[i] === 1'b0)   cs_low[i]  <= cs_low[i] + 1;
      if (o_ld[i] === 1'b0)   ld_low[i]  <= ld_low[i] + 1;
      if (o_busy[i] === 1'b1) busy_hi[i] <= busy_hi[i] + 1;
      if (o_done[i] === 1'b1) done_n[i]  <= done_n[i] + 1;
    end
  end

  always @(posedge o_sck[0]) begin
    fr_obs[0]    <= {fr_obs[0][14:0], o_sdi[0]};
    rise_prev[0] <= rise_last[0];
    rise_last[0] <= $time;
  end

  always @(posedge o_sck[1]) begin
    fr_obs[1]    <= {fr_obs[1][14:0], o_sdi[1]};
    rise_prev[1] <= rise_last[1];
    rise_last[1] <= $time;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int b_cs, b_ld, b_busy, b_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic compare_loop();
    logic [5:0] e, m, a;
    forever begin
      @(negedge sysclk);
      for (int i = 0; i < 2; i++) begin
        expect_out(m_k[i], cd_of(i), m_fr[i], e, m);
        a = {o_cs[i], o_sck[i], o_sdi[i], o_ld[i], o_busy[i], o_done[i]};
        n_cmp++;
        if ((a & m) !== (e & m)) begin
          n_bad++;
          $display("FAIL cycle_model[%0d] t=%0t k=%0d actual=%b required=%b mask=%b",
                   i, $time, m_k[i], a, e, m);
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic do_load(input int i, input logic [9:0] d);
    din[i]   = d;
    ld_in[i] = 1'b1;
    tick(1);
    ld_in[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge sysclk);
      n++;
      if (o_done[i] === 1'b1) seen = 1'b1;
    end
    chk($sformatf("done_seen[%0d]", i), 64'(seen), 64'd1);
  endtask

  task automatic snap(input int i);
    b_cs   = cs_low[i];
    b_ld   = ld_low[i];
    b_busy = busy_hi[i];
    b_done = done_n[i];
  endtask

  initial begin
    logic [9:0] d;
    ld_in[0] = 1'b0; ld_in[1] = 1'b0;
    din[0]   = '0;   din[1]   = '0;
    rst      = 1'b1;
    fork
      compare_loop();
    join_none
    tick(3);
    rst = 1'b0;
    @(negedge sysclk);
    chk("reset_pins_a", 64'({o_cs[0], o_sck[0], o_sdi[0], o_ld[0], o_busy[0], o_done[0]}), 64'b100100);
    chk("reset_pins_b", 64'({o_cs[1], o_sck[1], o_sdi[1], o_ld[1], o_busy[1], o_done[1]}), 64'b100100);

    // single frame 0x2AB
    snap(0);
    do_load(0, 10'h2AB);
    chk("load_to_cs_latency", 64'(o_cs[0]), 64'd0);
    wait_done(0, 80);
    tick(1);
    chk("frame_2ab", 64'(fr_obs[0]), 64'h7AAC);
    chk("cs_low_cycles", 64'(cs_low[0] - b_cs), 64'd64);
    chk("ld_low_cycles", 64'(ld_low[0] - b_ld), 64'd2);
    chk("busy_cycles", 64'(busy_hi[0] - b_busy), 64'd66);
    chk("done_pulses", 64'(done_n[0] - b_done), 64'd1);

    // back-to-back: second load lands on the done cycle
    tick(3);
    snap(0);
    do_load(0, 10'h000);
    wait_done(0, 80);
    chk("frame_000", 64'(fr_obs[0]), 64'h7000);
    din[0]   = 10'h3FF;
    ld_in[0] = 1'b1;
    tick(1);
    ld_in[0] = 1'b0;
    chk("b2b_cs_latency", 64'(o_cs[0]), 64'd0);
    wait_done(0, 80);
    tick(1);
    chk("frame_3ff", 64'(fr_obs[0]), 64'h7FFC);
    chk("b2b_done_pulses", 64'(done_n[0] - b_done), 64'd2);

    // spurious loads around ticks 5 and 20 are ignored
    tick(2);
    snap(0);
    d = 10'($urandom);
    do_load(0, d);
    tick(9);
    do_load(0, ~d);
    tick(29);
    do_load(0, d ^ 10'h155);
    wait_done(0, 80);
    tick(1);
    chk("frame_ignore_loads", 64'(fr_obs[0]), 64'({4'b0111, d, 2'b00}));
    chk("ignore_done_pulses", 64'(done_n[0] - b_done), 64'd1);
    chk("ignore_busy_cycles", 64'(busy_hi[0] - b_busy), 64'd66);

    // reset at tick 10 aborts the frame
    tick(2);
    do_load(0, 10'h3C3);
    tick(20);
    rst = 1'b1;
    #1;
    chk("abort_cs", 64'(o_cs[0]), 64'd1);
    chk("abort_sck", 64'(o_sck[0]), 64'd0);
    snap(0);
    tick(2);
    rst = 1'b0;
    tick(100);
    chk("abort_no_ld", 64'(ld_low[0] - b_ld), 64'd0);
    chk("abort_no_done", 64'(done_n[0] - b_done), 64'd0);
    do_load(0, 10'h155);
    wait_done(0, 80);
    tick(1);
    chk("frame_after_abort", 64'(fr_obs[0]), 64'h7554);

    // data_in churns every cycle after the accepting load
    tick(2);
    do_load(0, 10'h181);
    fork
      repeat (70) begin
        @(posedge sysclk);
        #1 din[0] = 10'($urandom);
      end
    join_none
    wait_done(0, 80);
    tick(6);
    chk("frame_181", 64'(fr_obs[0]), 64'h7604);

    // random traffic against the model
    repeat (600) begin
      ld_in[0] = ($urandom_range(0, 5) == 0);
      din[0]   = 10'($urandom);
      tick(1);
    end
    ld_in[0] = 1'b0;
    tick(80);

    // slow instance
    snap(1);
    do_load(1, 10'h200);
    wait_done(1, 900);
    tick(1);
    chk("slow_frame_200", 64'(fr_obs[1]), 64'h7800);
    chk("slow_busy_cycles", 64'(busy_hi[1] - b_busy), 64'd825);
    chk("slow_cs_low_cycles", 64'(cs_low[1] - b_cs), 64'd800);
    chk("slow_sck_period", 64'((rise_last[1] - rise_prev[1]) / 10), 64'd50);
    chk("slow_done_pulses", 64'(done_n[1] - b_done), 64'd1);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
